// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store, one transaction at a time.
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req_* / if_resp_*       fetch request handshake and read response
//   ls_req_* / ls_resp_*       load/store request handshake and response
//   mem_req_* / mem_resp_*     shared memory request and response
//   busy                       high whenever the arbiter is not idle
//   err                        sticky flag: memory response arrived when none was awaited
module mem_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                ls_req_valid,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_wen,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy,
  output logic                err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;
  localparam logic [3:0] MAX_S = 4'(MAX_LS_STREAK);
  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [3:0]          streak_q, streak_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                ls_win, if_win, resp;
  // owner_q: 1 = load/store, 0 = fetch; fetch takes over once the load/store streak hits the limit
  assign ls_win = ls_req_valid && !(if_req_valid && streak_q == MAX_S);
  assign if_win = if_req_valid && !ls_win;
  assign resp   = state_q == WAIT_RESP && mem_resp_valid;
  // readies are combinational from the requesters, so they are also masked while reset is held
  assign if_req_ready  = rst_n && state_q == IDLE && if_win;
  assign ls_req_ready  = rst_n && state_q == IDLE && ls_win;
  assign if_resp_valid = resp && !owner_q;
  assign ls_resp_valid = resp && owner_q;
  assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
  assign ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign busy          = state_q != IDLE;
  assign err           = err_q;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    err_d    = err_q || (mem_resp_valid && state_q != WAIT_RESP);
    case (state_q)
      IDLE: if (ls_win || if_win) begin
        state_d  = REQ;
        owner_d  = ls_win;
        streak_d = (ls_win && if_req_valid) ? streak_q + 4'd1 : 4'd0;
        addr_d   = ls_win ? ls_req_addr : if_req_addr;
        wen_d    = ls_win && ls_req_wen;
        wdata_d  = ls_win ? ls_req_wdata : '0;
        wmask_d  = ls_win ? ls_req_wmask : '0;
      end
      REQ:       state_d = mem_req_ready ? WAIT_RESP : REQ;
      WAIT_RESP: state_d = mem_resp_valid ? IDLE : WAIT_RESP;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 64, DW = 64, MW = 8, MAXS = 4;
  logic clk = 0, rst_n = 0;
  logic if_req_valid, if_req_ready, if_resp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_resp_data;
  logic ls_req_valid, ls_req_wen, ls_req_ready, ls_resp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata, ls_resp_data;
  logic [MW-1:0] ls_req_wmask;
  logic mem_req_valid, mem_req_wen, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, mem_resp_data;
  logic [MW-1:0] mem_req_wmask;
  logic busy, err;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
    .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {bit ls; logic [AW-1:0] addr; logic wen; logic [DW-1:0] wdata; logic [MW-1:0] wmask;} req_t;
  typedef struct {bit ls; logic [DW-1:0] data;} rsp_t;
  req_t gq[$], mq[$];
  rsp_t rq[$];
  int n_chk = 0, n_fail = 0;
  int ph = 0, streak = 0;
  bit cur_ls = 0, exp_err = 0, mon_en = 0;
  req_t mg, mm;
  rsp_t mr;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: phase 0 = free, 1 = request offered to memory, 2 = awaiting data.
  // Evaluates the inputs driven for this cycle, pushes expectations, then advances one clock.
  task automatic cyc();
    int nph;
    bit w, nerr;
    req_t g;
    rsp_t r;
    nph = ph;
    nerr = exp_err;
    if (ph == 0 && (if_req_valid || ls_req_valid)) begin
      w = ls_req_valid && !(if_req_valid && streak == MAXS);
      g.ls = w;
      g.addr = w ? ls_req_addr : if_req_addr;
      g.wen = w ? ls_req_wen : 1'b0;
      g.wdata = w ? ls_req_wdata : '0;
      g.wmask = w ? ls_req_wmask : '0;
      gq.push_back(g);
      mq.push_back(g);
      streak = (w && if_req_valid) ? streak + 1 : 0;
      cur_ls = w;
      nph = 1;
    end else if (ph == 1 && mem_req_ready) nph = 2;
    else if (ph == 2 && mem_resp_valid) begin
      r.ls = cur_ls;
      r.data = mem_resp_data;
      rq.push_back(r);
      nph = 0;
    end
    if (mem_resp_valid && ph != 2) nerr = 1;
    @(posedge clk);
    #1;
    ph = nph;
    exp_err = nerr;
  endtask
  task automatic rnd_in(input int p_if, input int p_ls);
    if_req_valid = ($urandom % 100) < p_if;
    if_req_addr = {$urandom, $urandom};
    ls_req_valid = ($urandom % 100) < p_ls;
    ls_req_addr = {$urandom, $urandom};
    ls_req_wen = $urandom % 2;
    ls_req_wdata = {$urandom, $urandom};
    ls_req_wmask = MW'($urandom);
    mem_req_ready = ($urandom % 3) != 0;
    mem_resp_valid = ph == 2 && ($urandom % 2) == 1;
    mem_resp_data = {$urandom, $urandom};
  endtask
  always @(negedge clk) if (mon_en) begin
    check("busy", busy, ph != 0);
    check("mem_req_valid", mem_req_valid, ph == 1);
    check("err", err, exp_err);
    if (gq.size() > 0) begin
      mg = gq.pop_front();
      check("if_req_ready", if_req_ready, !mg.ls);
      check("ls_req_ready", ls_req_ready, mg.ls);
    end else check("no_ready", {if_req_ready, ls_req_ready}, 0);
    if (mem_req_valid) begin
      check("mem_req_expected", mq.size() != 0, 1);
      if (mq.size() != 0) begin
        mm = mq[0];
        check("mem_req_addr", mem_req_addr, mm.addr);
        check("mem_req_wen", mem_req_wen, mm.wen);
        check("mem_req_wmask", mem_req_wmask, mm.wmask);
        if (mm.ls) check("mem_req_wdata", mem_req_wdata, mm.wdata);
        if (mem_req_ready) void'(mq.pop_front());
      end
    end
    if (rq.size() > 0) begin
      mr = rq.pop_front();
      check("if_resp_valid", if_resp_valid, !mr.ls);
      check("ls_resp_valid", ls_resp_valid, mr.ls);
      check("resp_data", mr.ls ? ls_resp_data : if_resp_data, mr.data);
    end else check("no_resp", {if_resp_valid, ls_resp_valid}, 0);
  end
  task automatic idle_in();
    if_req_valid = 0;
    ls_req_valid = 0;
    mem_req_ready = 0;
    mem_resp_valid = 0;
  endtask
  initial begin
    idle_in();
    if_req_valid = 1;
    ls_req_valid = 1;
    if_req_addr = '0;
    ls_req_addr = '0;
    ls_req_wen = 0;
    ls_req_wdata = '0;
    ls_req_wmask = '0;
    mem_resp_data = '0;
    #12;
    check("rst_if_ready", if_req_ready, 0);
    check("rst_ls_ready", ls_req_ready, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_resp", {if_resp_valid, ls_resp_valid}, 0);
    idle_in();
    @(posedge clk);
    #1;
    rst_n = 1;
    mon_en = 1;
    if_req_valid = 1;
    if_req_addr = 64'h8000_0000;
    mem_req_ready = 1;
    cyc();
    if_req_valid = 0;
    cyc();
    mem_resp_valid = 1;
    mem_resp_data = 64'h0010_0073;
    cyc();
    mem_resp_valid = 0;
    cyc();
    ls_req_valid = 1;
    ls_req_addr = 64'h8000_1000;
    ls_req_wen = 1;
    ls_req_wdata = 64'h1234;
    ls_req_wmask = 8'hFF;
    if_req_valid = 1;
    if_req_addr = 64'h8000_0004;
    cyc();
    ls_req_valid = 0;
    cyc();
    mem_resp_valid = 1;
    mem_resp_data = 64'hAAAA;
    cyc();
    mem_resp_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = ph == 2;
      mem_resp_data = 64'h100 + 64'(i);
      cyc();
    end
    if_req_valid = 1;
    ls_req_valid = 1;
    for (int i = 0; i < 24; i++) begin
      mem_resp_valid = ph == 2;
      mem_resp_data = {$urandom, $urandom};
      ls_req_addr = 64'h9000_0000 + 64'(i * 8);
      cyc();
    end
    idle_in();
    mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = ph == 2;
      cyc();
    end
    idle_in();
    ls_req_valid = 1;
    ls_req_wen = 1;
    ls_req_addr = 64'h8000_2000;
    ls_req_wdata = 64'hDEAD_BEEF;
    ls_req_wmask = 8'h0F;
    cyc();
    for (int i = 0; i < 5; i++) begin
      rnd_in(50, 50);
      mem_req_ready = 0;
      mem_resp_valid = 0;
      cyc();
    end
    idle_in();
    mem_req_ready = 1;
    cyc();
    mem_resp_valid = 1;
    mem_resp_data = 64'h5555;
    cyc();
    for (int i = 0; i < 400; i++) begin
      rnd_in(60, 60);
      cyc();
    end
    for (int i = 0; i < 6; i++) begin
      idle_in();
      mem_req_ready = 1;
      mem_resp_valid = ph == 2;
      cyc();
    end
    idle_in();
    mem_resp_valid = 1;
    cyc();
    mem_resp_valid = 0;
    cyc();
    cyc();
    if_req_valid = 1;
    if_req_addr = 64'h8000_0100;
    cyc();
    if_req_valid = 0;
    mem_req_ready = 1;
    cyc();
    mem_req_ready = 0;
    #3;
    rst_n = 0;
    ph = 0;
    streak = 0;
    exp_err = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_mem_valid", mem_req_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    mem_resp_valid = 1;
    mem_resp_data = 64'h7777;
    cyc();
    mem_resp_valid = 0;
    cyc();
    cyc();
    mon_en = 0;
    check("queues_drained", gq.size() + mq.size() + rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the width of all address ports.
REQ-002 Parameter DATA_W, default 64, SHALL set the width of all data ports; mask width SHALL be DATA_W/8.
REQ-003 Parameter MAX_LS_STREAK, default 4, SHALL set the maximum number of consecutive load/store grants while a fetch is pending; legal range 1..15.
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 if_req_valid  in  1  SHALL indicate an instruction-fetch request.
REQ-007 if_req_addr  in  ADDR_W  SHALL be the fetch address.
REQ-008 if_req_ready  out  1  SHALL indicate that the fetch request is accepted this cycle.
REQ-009 if_resp_valid  out  1  SHALL indicate that fetch read data is valid.
REQ-010 if_resp_data  out  DATA_W  SHALL be the fetch read data.
REQ-011 ls_req_valid  in  1  SHALL indicate a load/store request.
REQ-012 ls_req_addr  in  ADDR_W, ls_req_wen  in  1, ls_req_wdata  in  DATA_W, ls_req_wmask  in  DATA_W/8  SHALL carry the load/store address, write enable, write data and byte mask.
REQ-013 ls_req_ready  out  1  SHALL indicate that the load/store request is accepted this cycle.
REQ-014 ls_resp_valid  out  1  SHALL indicate load data valid, or write completion when the request was a store.
REQ-015 ls_resp_data  out  DATA_W  SHALL be the load read data.
REQ-016 mem_req_valid  out  1, mem_req_addr  out  ADDR_W, mem_req_wen  out  1, mem_req_wdata  out  DATA_W, mem_req_wmask  out  DATA_W/8  SHALL form the shared memory request.
REQ-017 mem_req_ready  in  1  SHALL indicate that the memory accepts the request.
REQ-018 mem_resp_valid  in  1, mem_resp_data  in  DATA_W  SHALL form the memory response.
REQ-019 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-020 err  out  1  SHALL be a sticky protocol-error flag.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, REQ, and WAIT_RESP; at most one transaction SHALL be outstanding at any time.
REQ-022 In IDLE, when either requester's valid is high, the arbiter SHALL assert exactly one ready (combinationally) for the winning requester, latch that requester's request fields and its owner ID, and move to REQ.
REQ-023 Arbitration SHALL use a fixed priority of load/store over fetch, with one exception: when if_req_valid is high and streak == MAX_LS_STREAK, fetch SHALL win.
REQ-024 streak (4 bits) SHALL increment on a load/store grant while if_req_valid is high.
REQ-025 streak SHALL clear on any fetch grant, and on a load/store grant while if_req_valid is low.
REQ-026 Fetch grants SHALL force mem_req_wen = 0 and mem_req_wmask = 0.
REQ-027 In REQ, mem_req_valid SHALL be held at 1 with the latched fields stable until mem_req_ready = 1; in that cycle the FSM SHALL move to WAIT_RESP.
REQ-028 In WAIT_RESP, when mem_resp_valid = 1, the arbiter SHALL pulse the owner's resp_valid for one cycle in that same cycle, with resp_data = mem_resp_data, and return to IDLE.
REQ-029 The non-owner's resp_valid SHALL stay low throughout.
REQ-030 Minimum latency from request acceptance to response SHALL be 2 cycles, achieved when mem_req_ready = 1 in the first REQ cycle and mem_resp_valid = 1 in the first WAIT_RESP cycle.
REQ-031 A new grant SHALL NOT occur in the same cycle as a response; the earliest next grant is the following IDLE cycle.
REQ-032 mem_req_valid SHALL be 0 outside REQ.
REQ-033 Both req_ready outputs SHALL be 0 outside IDLE.
REQ-034 mem_resp_valid = 1 in IDLE or REQ SHALL set err = 1 and SHALL otherwise be ignored.
REQ-035 err SHALL clear only on reset.
REQ-036 Requester valid/field changes outside IDLE SHALL NOT affect the latched request.

Reset
REQ-037 rst_n = 0 SHALL asynchronously force state = IDLE, streak = 0, err = 0, and owner = fetch.
REQ-038 rst_n = 0 SHALL asynchronously clear all latched request fields and SHALL drive all outputs to 0.
REQ-039 Reset asserted mid-transaction SHALL abandon the transaction without emitting any response; no response SHALL follow deassertion.
REQ-040 The first grant after rst_n deasserts SHALL be possible in the first clock edge's cycle with rst_n = 1.

Verification
REQ-041 Fetch only: if_req_valid = 1 with addr 0x80000000; mem_req_ready = 1 immediately; mem_resp_valid = 1 with data 0x00100073 one cycle later -> if_req_ready pulses at cycle 0, mem_req_valid at cycle 1, and if_resp_valid with data 0x00100073 at cycle 2; ls_resp_valid stays 0.
REQ-042 Simultaneous requests: a store (addr 0x80001000, wdata 0x1234, wmask 0xFF) and a fetch are both valid -> the store is granted first with mem_req_wen = 1; the fetch is granted in the first IDLE cycle after ls_resp_valid.
REQ-043 Starvation guard: ls_req_valid and if_req_valid are held high, MAX_LS_STREAK = 4 -> grant order is LS, LS, LS, LS, IF, LS..., and streak returns to 0 after the fetch grant.
REQ-044 Backpressure: mem_req_ready is held 0 for 5 cycles -> mem_req_valid stays 1 with addr/wdata unchanged while the requester changes its inputs; the response is routed to the original owner.
REQ-045 Spurious response: mem_resp_valid = 1 in IDLE -> err = 1, no resp_valid pulse, and err stays 1 until rst_n = 0.
REQ-046 Reset mid-operation: rst_n driven 0 during WAIT_RESP, between clock edges -> busy = 0 immediately; a later mem_resp_valid produces no resp_valid but sets err if it occurs in IDLE.
